fifo_dual_pop: RTL and testbench
================================

FIFO_DUAL_POP -- requirements
Module: fifo_dual_pop

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, entry width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, pointer width.
REQ-003 The block SHALL have parameter RAM_DEPTH, default 1<<ADDR_WIDTH, storage slots.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port push  input  1  write request for data_in.
REQ-007 The block SHALL have port data_in  input  DATA_WIDTH  write data.
REQ-008 The block SHALL have port pop0  input  1  request to read the oldest entry.
REQ-009 The block SHALL have port pop1  input  1  request to read the second-oldest entry, honoured only together with pop0.
REQ-010 The block SHALL have port data_out0  output  DATA_WIDTH  registered oldest popped entry.
REQ-011 The block SHALL have port data_out1  output  DATA_WIDTH  registered second popped entry.
REQ-012 The block SHALL have port valid0  output  1  one-cycle pulse: data_out0 updated by a pop.
REQ-013 The block SHALL have port valid1  output  1  one-cycle pulse: data_out1 updated by a pop.
REQ-014 The block SHALL have port count  output  ADDR_WIDTH+1  current occupancy.
REQ-015 The block SHALL have ports empty and full  output  1 each  occupancy flags.
REQ-016 The block SHALL have port drop  output  1  one-cycle pulse: a push was rejected.

Function
REQ-017 Capacity SHALL be RAM_DEPTH-1 entries; full = (count == RAM_DEPTH-1); empty = (count == 0); both combinational from count.
REQ-018 write SHALL be push && !full, evaluated on pre-edge count; pops in the same cycle do not free space for it.
REQ-019 read0 SHALL be pop0 && (count >= 1).
REQ-020 read1 SHALL be pop0 && pop1 && (count >= 2); pop1 without pop0 is ignored.
REQ-021 On write, mem[wr_ptr] <= data_in and wr_ptr <= wr_ptr+1, modulo RAM_DEPTH.
REQ-022 On read0, data_out0 <= mem[rd_ptr]; on read1, data_out1 <= mem[rd_ptr+1] (index modulo RAM_DEPTH).
REQ-023 rd_ptr SHALL advance by read0+read1, modulo RAM_DEPTH.
REQ-024 Read latency SHALL be one cycle: valid0/valid1 are registered copies of read0/read1, high for exactly one cycle.
REQ-025 data_out0/data_out1 SHALL hold their last value when not loaded.
REQ-026 count SHALL update to count + write - read0 - read1 every cycle, including simultaneous push and pop.
REQ-027 There is no write-to-read bypass: an entry pushed in cycle N is first poppable in cycle N+1.
REQ-028 drop SHALL be registered push && full, one cycle after the rejected push.
REQ-029 When pop0 && pop1 are requested with count == 1, only read0 SHALL occur and valid1 stays low.
REQ-030 Pop requests on an empty FIFO SHALL be ignored; pointers, count and outputs are unchanged.

Reset
REQ-031 Asserting reset SHALL immediately clear wr_ptr, rd_ptr, count, data_out0, data_out1, valid0, valid1 and drop to 0, independent of clk.
REQ-032 Memory contents SHALL NOT be reset; they are unobservable until rewritten.
REQ-033 Reset asserted mid-operation SHALL discard all entries; the first pop after release returns the first post-reset push.

Verification
REQ-034 Push 0xA, 0xB, 0xC on consecutive cycles, then one cycle of pop0+pop1 -> the next cycle has data_out0=0xA, data_out1=0xB, valid0=valid1=1, count=1.
REQ-035 Fill with 31 pushes -> full=1, count=31; a 32nd push together with pop0 -> drop=1, push rejected, count=30.
REQ-036 count=1 holding 0x5, pop0+pop1 -> data_out0=0x5, valid0=1, valid1=0, empty=1; data_out1 is unchanged.
REQ-037 Cycle 40 entries (push/pop at steady rate) so both pointers wrap past 31 -> output order preserved; a dual pop straddling index 31/0 returns the correct pair.
REQ-038 count=3, push and pop0+pop1 in the same cycle -> count=2, with the pushed entry last in order.
REQ-039 Assert reset asynchronously between clock edges with count=5 -> count=0, empty=1, valid0=valid1=0 before the next edge; after release, push 0x7 then pop0 -> data_out0=0x7.

Source files
------------

// File: rtl/fifo_dual_pop_if.sv
// Push/dual-pop handshake bundle for fifo_dual_pop; master drives requests, slave returns data and status.
// All signals are sampled or launched on the rising edge of the FIFO clock.
interface fifo_dual_pop_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  push;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pop0;
   logic                  pop1;
   logic [DATA_WIDTH-1:0] data_out0;
   logic [DATA_WIDTH-1:0] data_out1;
   logic                  valid0;
   logic                  valid1;
   logic [ADDR_WIDTH:0]   count;
   logic                  empty;
   logic                  full;
   logic                  drop;

   modport master (
      output push, data_in, pop0, pop1,
      input  data_out0, data_out1, valid0, valid1, count, empty, full, drop
   );

   modport slave (
      input  push, data_in, pop0, pop1,
      output data_out0, data_out1, valid0, valid1, count, empty, full, drop
   );
endinterface

// File: rtl/fifo_dual_pop.sv
// FIFO that pops one or two oldest entries per cycle; popped data is registered, one-cycle latency.
// No backpressure: pushes into a full FIFO are rejected and flagged by drop, pops beyond occupancy are ignored.
module fifo_dual_pop #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
   input  logic           clk,
   input  logic           reset,
   fifo_dual_pop_if.slave bus
);
   typedef logic [ADDR_WIDTH-1:0] ptr_t;
   typedef logic [ADDR_WIDTH:0]   cnt_t;

   localparam cnt_t DEPTH_C = cnt_t'(RAM_DEPTH);
   localparam cnt_t CAP_C   = cnt_t'(RAM_DEPTH - 1);
   localparam cnt_t ONE_C   = cnt_t'(1);
   localparam cnt_t TWO_C   = cnt_t'(2);

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   ptr_t                  wr_ptr;
   ptr_t                  rd_ptr;
   ptr_t                  rd_ptr_p1;
   cnt_t                  count_q;
   cnt_t                  rd_step;
   cnt_t                  wr_step;
   logic                  full_c;
   logic                  empty_c;
   logic                  write;
   logic                  read0;
   logic                  read1;
   logic [DATA_WIDTH-1:0] data_out0_q;
   logic [DATA_WIDTH-1:0] data_out1_q;
   logic                  valid0_q;
   logic                  valid1_q;
   logic                  drop_q;

   // Step is at most 2, so the sum always fits one bit above the pointer width.
   function automatic ptr_t ptr_add(input ptr_t p, input cnt_t step);
      cnt_t sum;
      sum = cnt_t'(p) + step;
      if (sum >= DEPTH_C) begin
         sum = sum - DEPTH_C;
      end
      return sum[ADDR_WIDTH-1:0];
   endfunction

   assign full_c    = (count_q == CAP_C);
   assign empty_c   = (count_q == '0);
   assign write     = bus.push && !full_c;
   assign read0     = bus.pop0 && (count_q >= ONE_C);
   assign read1     = bus.pop0 && bus.pop1 && (count_q >= TWO_C);
   assign rd_ptr_p1 = ptr_add(rd_ptr, ONE_C);
   assign rd_step   = read1 ? TWO_C : (read0 ? ONE_C : '0);
   assign wr_step   = write ? ONE_C : '0;

   // Storage is left unreset; slots are only observable after being written.
   always_ff @(posedge clk) begin
      if (write) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         data_out0_q <= '0;
         data_out1_q <= '0;
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         if (write) begin
            wr_ptr <= ptr_add(wr_ptr, ONE_C);
         end
         if (read0) begin
            data_out0_q <= mem[rd_ptr];
         end
         if (read1) begin
            data_out1_q <= mem[rd_ptr_p1];
         end
         rd_ptr   <= ptr_add(rd_ptr, rd_step);
         count_q  <= count_q + wr_step - rd_step;
         valid0_q <= read0;
         valid1_q <= read1;
         drop_q   <= bus.push && full_c;
      end
   end

   assign bus.data_out0 = data_out0_q;
   assign bus.data_out1 = data_out1_q;
   assign bus.valid0    = valid0_q;
   assign bus.valid1    = valid1_q;
   assign bus.count     = count_q;
   assign bus.empty     = empty_c;
   assign bus.full      = full_c;
   assign bus.drop      = drop_q;
endmodule

// File: tb/tb_fifo_dual_pop.sv
// Bench for fifo_dual_pop: directed scenarios with literal expectations plus a randomized run
// against a queue-based reference model.
module tb_fifo_dual_pop;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;
   localparam int CAP   = DEPTH - 1;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   fifo_dual_pop_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_dual_pop #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: contents in order, plus the expected registered outputs.
   logic [DW-1:0] q [$];
   logic [DW-1:0] exp_d0;
   logic [DW-1:0] exp_d1;
   logic          exp_v0;
   logic          exp_v1;
   logic          exp_drop;

   task automatic model_clear();
      q.delete();
      exp_d0   = '0;
      exp_d1   = '0;
      exp_v0   = 1'b0;
      exp_v1   = 1'b0;
      exp_drop = 1'b0;
   endtask

   // Drive one cycle of requests from a falling edge; returns on the next falling edge.
   task automatic step(input logic ps, input logic [DW-1:0] d, input logic p0, input logic p1);
      int n;
      bus.push    = ps;
      bus.data_in = d;
      bus.pop0    = p0;
      bus.pop1    = p1;
      @(posedge clk);
      n        = q.size();
      exp_drop = ps && (n == CAP);
      exp_v0   = p0 && (n >= 1);
      exp_v1   = p0 && p1 && (n >= 2);
      if (exp_v0) exp_d0 = q[0];
      if (exp_v1) exp_d1 = q[1];
      if (exp_v0) void'(q.pop_front());
      if (exp_v1) void'(q.pop_front());
      if (ps && (n != CAP)) q.push_back(d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_clear();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset       = 1'b1;
      bus.push    = 1'b0;
      bus.data_in = '0;
      bus.pop0    = 1'b0;
      bus.pop1    = 1'b0;
      model_clear();
      #1;
      total++; if (bus.count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
      total++; if ({bus.empty, bus.full} !== 2'b10) begin bad++; $display("FAIL reset_flags got=%b want=10", {bus.empty, bus.full}); end
      total++; if ({bus.valid0, bus.valid1, bus.drop} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {bus.valid0, bus.valid1, bus.drop}); end
      total++; if ({bus.data_out0, bus.data_out1} !== 64'h0) begin bad++; $display("FAIL reset_data got=%h want=0", {bus.data_out0, bus.data_out1}); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_basic_dual();
      step(1'b1, 32'hA, 1'b0, 1'b0);
      step(1'b1, 32'hB, 1'b0, 1'b0);
      step(1'b1, 32'hC, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (bus.data_out0 !== 32'hA) begin bad++; $display("FAIL basic_d0 got=%h want=a", bus.data_out0); end
      total++; if (bus.data_out1 !== 32'hB) begin bad++; $display("FAIL basic_d1 got=%h want=b", bus.data_out1); end
      total++; if ({bus.valid0, bus.valid1} !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b want=11", {bus.valid0, bus.valid1}); end
      total++; if (bus.count !== 6'd1) begin bad++; $display("FAIL basic_count got=%0d want=1", bus.count); end
      step(1'b0, '0, 1'b0, 1'b0);
      total++; if ({bus.valid0, bus.valid1} !== 2'b00) begin bad++; $display("FAIL basic_pulse got=%b want=00", {bus.valid0, bus.valid1}); end
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (bus.data_out0 !== 32'hC || bus.empty !== 1'b1) begin bad++; $display("FAIL basic_last got=%h/%b want=c/1", bus.data_out0, bus.empty); end
   endtask

   task automatic test_full_drop();
      for (int i = 0; i < CAP; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
      total++; if (bus.full !== 1'b1 || bus.count !== 6'd31) begin bad++; $display("FAIL full_flag got=%b/%0d want=1/31", bus.full, bus.count); end
      step(1'b1, 32'd999, 1'b1, 1'b0);
      total++; if (bus.drop !== 1'b1) begin bad++; $display("FAIL full_drop got=%b want=1", bus.drop); end
      total++; if (bus.count !== 6'd30) begin bad++; $display("FAIL full_count got=%0d want=30", bus.count); end
      total++; if (bus.data_out0 !== 32'd100) begin bad++; $display("FAIL full_d0 got=%0d want=100", bus.data_out0); end
      step(1'b0, '0, 1'b0, 1'b0);
      total++; if (bus.drop !== 1'b0) begin bad++; $display("FAIL drop_pulse got=%b want=0", bus.drop); end
      for (int i = 0; i < 15; i++) begin
         step(1'b0, '0, 1'b1, 1'b1);
         total++;
         if (bus.data_out0 !== 32'(101 + 2 * i) || bus.data_out1 !== 32'(102 + 2 * i)) begin
            bad++; $display("FAIL full_drain[%0d] got=%0d/%0d want=%0d/%0d", i, bus.data_out0, bus.data_out1, 101 + 2 * i, 102 + 2 * i);
         end
      end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL full_drained_empty got=%b want=1", bus.empty); end
   endtask

   task automatic test_single_dual();
      logic [DW-1:0] held;
      held = 32'd130;
      step(1'b1, 32'h5, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (bus.data_out0 !== 32'h5) begin bad++; $display("FAIL single_d0 got=%h want=5", bus.data_out0); end
      total++; if ({bus.valid0, bus.valid1, bus.empty} !== 3'b101) begin bad++; $display("FAIL single_flags got=%b want=101", {bus.valid0, bus.valid1, bus.empty}); end
      total++; if (bus.data_out1 !== held) begin bad++; $display("FAIL single_d1_hold got=%0d want=%0d", bus.data_out1, held); end
   endtask

   task automatic test_empty_pop();
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if ({bus.valid0, bus.valid1} !== 2'b00 || bus.count !== 6'd0) begin bad++; $display("FAIL empty_pop got=%b/%0d want=00/0", {bus.valid0, bus.valid1}, bus.count); end
      total++; if (bus.data_out0 !== 32'h5) begin bad++; $display("FAIL empty_pop_hold got=%h want=5", bus.data_out0); end
   endtask

   task automatic test_simul_push_pop();
      step(1'b1, 32'd1, 1'b0, 1'b0);
      step(1'b1, 32'd2, 1'b0, 1'b0);
      step(1'b1, 32'd3, 1'b0, 1'b0);
      step(1'b1, 32'd4, 1'b1, 1'b1);
      total++; if (bus.count !== 6'd2) begin bad++; $display("FAIL simul_count got=%0d want=2", bus.count); end
      total++; if (bus.data_out0 !== 32'd1 || bus.data_out1 !== 32'd2) begin bad++; $display("FAIL simul_pair got=%0d/%0d want=1/2", bus.data_out0, bus.data_out1); end
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (bus.data_out0 !== 32'd3 || bus.data_out1 !== 32'd4) begin bad++; $display("FAIL simul_order got=%0d/%0d want=3/4", bus.data_out0, bus.data_out1); end
   endtask

   task automatic test_wrap();
      do_reset();
      step(1'b1, 32'd1000, 1'b0, 1'b0);
      for (int i = 0; i < 31; i++) begin
         step(1'b1, 32'(1001 + i), 1'b1, 1'b0);
         total++;
         if (bus.data_out0 !== 32'(1000 + i) || bus.count !== 6'd1) begin
            bad++; $display("FAIL wrap_stream[%0d] got=%0d/%0d want=%0d/1", i, bus.data_out0, bus.count, 1000 + i);
         end
      end
      // Read pointer now sits on the last slot, so this dual pop straddles the wrap.
      step(1'b1, 32'd1032, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (bus.data_out0 !== 32'd1031 || bus.data_out1 !== 32'd1032) begin bad++; $display("FAIL wrap_straddle got=%0d/%0d want=1031/1032", bus.data_out0, bus.data_out1); end
      step(1'b1, 32'd1033, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 32'(1033 + i), 1'b1, 1'b0);
         total++;
         if (bus.data_out0 !== 32'(1032 + i)) begin bad++; $display("FAIL wrap_tail[%0d] got=%0d want=%0d", i, bus.data_out0, 1032 + i); end
      end
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (bus.data_out0 !== 32'd1039 || bus.empty !== 1'b1) begin bad++; $display("FAIL wrap_end got=%0d/%b want=1039/1", bus.data_out0, bus.empty); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 32'(2000 + i), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (bus.count !== 6'd5 || bus.valid0 !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0d/%b want=5/1", bus.count, bus.valid0); end
      #2 reset = 1'b1;
      #1;
      total++; if (bus.count !== 6'd0 || bus.empty !== 1'b1) begin bad++; $display("FAIL areset_count got=%0d/%b want=0/1", bus.count, bus.empty); end
      total++; if ({bus.valid0, bus.valid1} !== 2'b00) begin bad++; $display("FAIL areset_valid got=%b want=00", {bus.valid0, bus.valid1}); end
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 32'h7, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      total++; if (bus.data_out0 !== 32'h7 || bus.valid0 !== 1'b1) begin bad++; $display("FAIL areset_after got=%h/%b want=7/1", bus.data_out0, bus.valid0); end
   endtask

   task automatic test_random();
      logic ps, p0, p1;
      int   bias;
      for (int c = 0; c < 400; c++) begin
         bias = ((c / 50) % 2 == 0) ? 85 : 20;
         ps   = ($urandom_range(0, 99) < bias);
         p0   = ($urandom_range(0, 99) < 100 - bias);
         p1   = $urandom_range(0, 1) == 1;
         step(ps, $urandom, p0, p1);
         total++;
         if ({bus.valid0, bus.valid1, bus.drop} !== {exp_v0, exp_v1, exp_drop}) begin
            bad++; $display("FAIL rand_pulses[%0d] got=%b want=%b", c, {bus.valid0, bus.valid1, bus.drop}, {exp_v0, exp_v1, exp_drop});
         end
         total++;
         if (bus.count !== 6'(q.size()) || bus.empty !== (q.size() == 0) || bus.full !== (q.size() == CAP)) begin
            bad++; $display("FAIL rand_occupancy[%0d] got=%0d/%b/%b want=%0d", c, bus.count, bus.empty, bus.full, q.size());
         end
         total++;
         if (bus.data_out0 !== exp_d0 || bus.data_out1 !== exp_d1) begin
            bad++; $display("FAIL rand_data[%0d] got=%h/%h want=%h/%h", c, bus.data_out0, bus.data_out1, exp_d0, exp_d1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_dual();
      test_full_drop();
      test_single_dual();
      test_empty_pop();
      test_simul_push_pop();
      test_wrap();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
